// File: rtl/axil_sram_pkg.sv
// Shared constants and types for the AXI-Lite SRAM with a round-robin read/write port.
package axil_sram_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;
endpackage

// File: rtl/axil_sram_arb_if.sv
// AXI4-Lite bus bundle; the SRAM takes the slave modport, the driver the master modport.
interface axil_sram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid, wready;
  logic [1:0]            bresp;
  logic                  bvalid, bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid, arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid, rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axil_sram_rd_pipe.sv
// Read-data delay line: a read grant appears on the R channel READ_LATENCY cycles later,
// and the last stage holds its word until the R handshake.
module axil_sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            resp_i,
  input  logic                  rready_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o
);
  logic [READ_LATENCY:1]                 vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] dat_q, dat_d;
  logic [READ_LATENCY:1][1:0]            rsp_q, rsp_d;
  logic                                  hold;

  assign hold = vld_pipe_q[READ_LATENCY] && !rready_i;

  // Only one read is ever in flight, so the inner stages never need to stall.
  always_comb begin
    vld_pipe_d[1] = vld_i;
    dat_d[1]      = data_i;
    rsp_d[1]      = resp_i;
    for (int k = 2; k <= READ_LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      dat_d[k]      = dat_q[k-1];
      rsp_d[k]      = rsp_q[k-1];
    end
    if (hold) begin
      vld_pipe_d[READ_LATENCY] = vld_pipe_q[READ_LATENCY];
      dat_d[READ_LATENCY]      = dat_q[READ_LATENCY];
      rsp_d[READ_LATENCY]      = rsp_q[READ_LATENCY];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      dat_q      <= '0;
      rsp_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_q      <= dat_d;
      rsp_q      <= rsp_d;
    end
  end

  assign rvalid_o = vld_pipe_q[READ_LATENCY];
  assign rdata_o  = dat_q[READ_LATENCY];
  assign rresp_o  = rsp_q[READ_LATENCY];
endmodule

// File: rtl/axil_sram_arb.sv
// AXI4-Lite SRAM: independent AW/W/AR holding registers sharing one memory port,
// round-robin between read and write, SLVERR outside the array.
module axil_sram_arb
  import axil_sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int READ_LATENCY   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  axil_sram_arb_if.slave  s_axil
);
  localparam int ALIGN = $clog2(STRB_WIDTH);
  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

  logic                      aw_held_q, w_held_q, ar_busy_q, ar_granted_q;
  logic [ADDR_WIDTH-1:0]     awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;
  logic                      bvalid_q;
  logic [1:0]                bresp_q;
  grant_e                    last_grant_q;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic                      wr_req, rd_req, wr_gnt, rd_gnt;
  logic                      wr_oor, rd_oor;
  logic [MEM_ADDR_WIDTH-1:0] widx, ridx;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic [1:0]                rd_resp;
  logic                      unused_ok;

  // Any address bit above the word index means the access falls outside the array.
  assign wr_oor = (awaddr_q >> (ALIGN + MEM_ADDR_WIDTH)) != '0;
  assign rd_oor = (araddr_q >> (ALIGN + MEM_ADDR_WIDTH)) != '0;
  assign widx   = awaddr_q[ALIGN +: MEM_ADDR_WIDTH];
  assign ridx   = araddr_q[ALIGN +: MEM_ADDR_WIDTH];

  assign wr_req = aw_held_q && w_held_q && (!bvalid_q || s_axil.bready);
  assign rd_req = ar_busy_q && !ar_granted_q;
  assign wr_gnt = wr_req && (!rd_req || last_grant_q == GRANT_READ);
  assign rd_gnt = rd_req && (!wr_req || last_grant_q == GRANT_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      ar_busy_q    <= 1'b0;
      ar_granted_q <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      last_grant_q <= GRANT_WRITE;
    end else begin
      if (s_axil.awvalid && !aw_held_q) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= s_axil.awaddr;
      end else if (wr_gnt) begin
        aw_held_q <= 1'b0;
      end

      if (s_axil.wvalid && !w_held_q) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_axil.wdata;
        wstrb_q  <= s_axil.wstrb;
      end else if (wr_gnt) begin
        w_held_q <= 1'b0;
      end

      // arready stays low from AR capture until the R handshake retires the read.
      if (s_axil.arvalid && !ar_busy_q) begin
        ar_busy_q    <= 1'b1;
        ar_granted_q <= 1'b0;
        araddr_q     <= s_axil.araddr;
      end else begin
        if (rd_gnt) ar_granted_q <= 1'b1;
        if (s_axil.rvalid && s_axil.rready) ar_busy_q <= 1'b0;
      end

      if (wr_gnt) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil.bready) begin
        bvalid_q <= 1'b0;
      end

      if (wr_gnt)      last_grant_q <= GRANT_WRITE;
      else if (rd_gnt) last_grant_q <= GRANT_READ;
    end
  end

  // Array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_gnt && !wr_oor) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_q[b]) mem[widx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign rd_word = rd_oor ? '0 : mem[ridx];
  assign rd_resp = rd_oor ? RESP_SLVERR : RESP_OKAY;

  axil_sram_rd_pipe #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld_i    (rd_gnt),
    .data_i   (rd_word),
    .resp_i   (rd_resp),
    .rready_i (s_axil.rready),
    .rvalid_o (s_axil.rvalid),
    .rdata_o  (s_axil.rdata),
    .rresp_o  (s_axil.rresp)
  );

  assign s_axil.awready = !aw_held_q;
  assign s_axil.wready  = !w_held_q;
  assign s_axil.arready = !ar_busy_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;

  assign unused_ok = ^{s_axil.awprot, s_axil.arprot, awaddr_q[ALIGN-1:0], araddr_q[ALIGN-1:0]};
endmodule

// File: tb/tb_axil_sram_arb.sv
// Directed bench for axil_sram_arb with READ_LATENCY=3: handshakes, strobes, arbitration,
// SLVERR decode and mid-transaction reset.
module tb_axil_sram_arb;
  import axil_sram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_sram_arb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axil_sram_arb #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4),
    .MEM_ADDR_WIDTH(10), .READ_LATENCY(3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_axil (bus)
  );

  int passed = 0;
  int total  = 0;
  int b_cyc, r_cyc;
  logic [1:0]  bresp_s, rresp_s;
  logic [31:0] rdata_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present any mix of AW/W/AR in one cycle, then record the first cycle of bvalid/rvalid.
  task automatic run_txn(input bit aw, input bit w, input bit ar, input logic [15:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    bus.awvalid = aw; bus.awaddr = addr;
    bus.wvalid  = w;  bus.wdata  = data; bus.wstrb = strb;
    bus.arvalid = ar; bus.araddr = addr;
    b_cyc = -1; r_cyc = -1; bresp_s = '0; rresp_s = '0; rdata_s = '0;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.bvalid && b_cyc < 0) begin b_cyc = k; bresp_s = bus.bresp; end
      if (bus.rvalid && r_cyc < 0) begin r_cyc = k; rdata_s = bus.rdata; rresp_s = bus.rresp; end
      tick();
    end
  endtask

  task automatic wr(input string tag, input logic [15:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] exp_resp);
    run_txn(1'b1, 1'b1, 1'b0, addr, data, strb);
    chk({tag, "_bcyc"}, b_cyc, 2);
    chk({tag, "_bresp"}, {30'd0, bresp_s}, {30'd0, exp_resp});
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    run_txn(1'b0, 1'b0, 1'b1, addr, '0, '0);
    chk({tag, "_rcyc"}, r_cyc, 4);
    chk({tag, "_rdata"}, rdata_s, exp_data);
    chk({tag, "_rresp"}, {30'd0, rresp_s}, {30'd0, exp_resp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, {31'd0, bus.awready}, 1);
    chk({tag, "_wready"},  {31'd0, bus.wready},  1);
    chk({tag, "_arready"}, {31'd0, bus.arready}, 1);
    chk({tag, "_bvalid"},  {31'd0, bus.bvalid},  0);
    chk({tag, "_bresp"},   {30'd0, bus.bresp},   0);
    chk({tag, "_rvalid"},  {31'd0, bus.rvalid},  0);
    chk({tag, "_rresp"},   {30'd0, bus.rresp},   0);
    chk({tag, "_rdata"},   bus.rdata,            0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit spurious;
    logic [31:0] held;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;

    // Reset state
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // AW in cycle 1, W in cycle 3: bvalid in cycle 5
    tick(); bus.awvalid = 1'b1; bus.awaddr = 16'h0010;
    tick(); bus.awvalid = 1'b0;
    chk("t1_awready_held", {31'd0, bus.awready}, 0);
    tick(); bus.wvalid = 1'b1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    tick(); bus.wvalid = 1'b0;
    chk("t1_wready_held", {31'd0, bus.wready}, 0);
    chk("t1_bvalid_c4", {31'd0, bus.bvalid}, 0);
    tick();
    chk("t1_bvalid_c5", {31'd0, bus.bvalid}, 1);
    chk("t1_bresp", {30'd0, bus.bresp}, 0);
    tick();
    chk("t1_bvalid_c6", {31'd0, bus.bvalid}, 0);
    chk("t1_awready_free", {31'd0, bus.awready}, 1);
    rd("t1_rd", 16'h0010, 32'hDEADBEEF, RESP_OKAY);

    // Byte strobes merge into the existing word
    wr("t2_wr_full", 16'h0020, 32'hFFFFFFFF, 4'hF, RESP_OKAY);
    wr("t2_wr_byte", 16'h0020, 32'h00000012, 4'h1, RESP_OKAY);
    rd("t2_rd", 16'h0020, 32'hFFFFFF12, RESP_OKAY);

    // Read latency 3 and R-channel stall
    wr("t3_wr", 16'h0004, 32'hA5A50004, 4'hF, RESP_OKAY);
    bus.rready = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 16'h0004;
    tick(); bus.arvalid = 1'b0;
    chk("t3_arready_busy", {31'd0, bus.arready}, 0);
    tick(); tick();
    chk("t3_rvalid_c3", {31'd0, bus.rvalid}, 0);
    tick();
    chk("t3_rvalid_c4", {31'd0, bus.rvalid}, 1);
    chk("t3_rdata_c4", bus.rdata, 32'hA5A50004);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t3_stall_rvalid", {31'd0, bus.rvalid}, 1);
      chk("t3_stall_rdata", bus.rdata, 32'hA5A50004);
      chk("t3_stall_arready", {31'd0, bus.arready}, 0);
    end
    bus.rready = 1'b1;
    tick();
    chk("t3_rvalid_done", {31'd0, bus.rvalid}, 0);
    chk("t3_arready_free", {31'd0, bus.arready}, 1);

    // Arbitration: after a write grant, a conflict goes to the read (old data)
    wr("t4_seed", 16'h0030, 32'h11111111, 4'hF, RESP_OKAY);
    run_txn(1'b1, 1'b1, 1'b1, 16'h0030, 32'h22222222, 4'hF);
    chk("t4a_bcyc", b_cyc, 3);
    chk("t4a_rcyc", r_cyc, 4);
    chk("t4a_rdata", rdata_s, 32'h11111111);
    // After a read grant, a conflict goes to the write (new data)
    rd("t4_mid", 16'h0030, 32'h22222222, RESP_OKAY);
    run_txn(1'b1, 1'b1, 1'b1, 16'h0030, 32'h33333333, 4'hF);
    chk("t4b_bcyc", b_cyc, 2);
    chk("t4b_rcyc", r_cyc, 5);
    chk("t4b_rdata", rdata_s, 32'h33333333);

    // Out-of-range: 0x1000 must not alias onto word 0
    wr("t5_seed", 16'h0000, 32'h01020304, 4'hF, RESP_OKAY);
    wr("t5_oor_wr", 16'h1000, 32'hCAFEF00D, 4'hF, RESP_SLVERR);
    rd("t5_word0", 16'h0000, 32'h01020304, RESP_OKAY);
    rd("t5_oor_rd", 16'h1000, 32'h00000000, RESP_SLVERR);

    // Reset with bvalid stalled, a read in the pipe and an AW held
    rd("t6_pre", 16'h0020, 32'hFFFFFF12, RESP_OKAY);
    bus.bready = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = 16'h0040;
    bus.wvalid = 1'b1;  bus.wdata = 32'h00000055; bus.wstrb = 4'hF;
    tick(); bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    chk("t6_bvalid_held", {31'd0, bus.bvalid}, 1);
    bus.arvalid = 1'b1; bus.araddr = 16'h0040;
    tick(); bus.arvalid = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = 16'h0044;
    tick(); bus.awvalid = 1'b0;
    chk("t6_aw_captured", {31'd0, bus.awready}, 0);
    chk("t6_rvalid_pre", {31'd0, bus.rvalid}, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    bus.bready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.rvalid || bus.bvalid) spurious = 1'b1;
    end
    chk("t6_no_spurious", {31'd0, spurious}, 0);
    // last_grant returns to WRITE, so the first conflict after reset goes to the read
    run_txn(1'b1, 1'b1, 1'b1, 16'h0030, 32'h44444444, 4'hF);
    chk("t7_bcyc", b_cyc, 3);
    chk("t7_rcyc", r_cyc, 4);
    chk("t7_rdata", rdata_s, 32'h33333333);
    rd("t7_granted_wr", 16'h0040, 32'h00000055, RESP_OKAY);
    held = 32'h44444444;
    rd("t7_after", 16'h0030, held, RESP_OKAY);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
